// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze,
// saturating stall/flush event counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             memstall_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RdAddr_i,
  input  logic [4:0]       IFID_RS1_i,
  input  logic [4:0]       IFID_RS2_i,
  input  logic             Branch_i,
  output logic             PCWrite_o,
  output logic             IFID_Stall_o,
  output logic             IFID_Flush_o,
  output logic             NoOp_o,
  output logic             Global_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TO  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    MEMWAIT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               err_q, err_d;
  logic               hazard_s;
  logic               active_s;

  assign hazard_s = IDEX_MemRead_i && (IDEX_RdAddr_i != 5'd0) &&
                    ((IDEX_RdAddr_i == IFID_RS1_i) || (IDEX_RdAddr_i == IFID_RS2_i));

  // Mealy control outputs; while start_i is low the IDLE values are forced
  always_comb begin
    PCWrite_o      = 1'b0;
    IFID_Stall_o   = 1'b0;
    IFID_Flush_o   = 1'b0;
    NoOp_o         = 1'b0;
    Global_stall_o = 1'b0;
    if (!start_i) begin
      IFID_Flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN, MEMWAIT: begin
          if (memstall_i) begin
            Global_stall_o = 1'b1;
          end else if (hazard_s) begin
            IFID_Stall_o = 1'b1;
            NoOp_o       = 1'b1;
          end else if (Branch_i) begin
            PCWrite_o    = 1'b1;
            IFID_Flush_o = 1'b1;
          end else begin
            PCWrite_o = 1'b1;
          end
        end
        default: IFID_Flush_o = 1'b1;
      endcase
    end
  end

  // Next-state, wait timer, event counters and sticky timeout flag
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q || (wait_cnt_q == WAIT_TO);
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (memstall_i) begin
          state_d    = MEMWAIT;
          wait_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (memstall_i) begin
          state_d = MEMWAIT;
          if (wait_cnt_q != WAIT_TO) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // IDLE's forced flush is excluded from the event counts
    active_s = (state_q == RUN) || (state_q == MEMWAIT);
    if (active_s && !PCWrite_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (active_s && IFID_Flush_o && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default instance and a small one (CNT_W=4, TIMEOUT=4)
// share stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic       clk;
  logic       start, ms, ld, br;
  logic [4:0] rd, rs1, rs2;
  logic [1:0] pcw, istall, iflush, noop, gstall, err;
  logic [1:0] st0, st1;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int n_checks = 0;
  int n_pass   = 0;

  // model state per instance: mode 0=IDLE 1=RUN 2=MEMWAIT
  int m_st[2], m_sc[2], m_fc[2], m_dw[2];
  bit m_err[2];
  int m_to[2]   = '{64, 4};
  int m_cmax[2] = '{65535, 15};

  hazard_ctrl dut0 (
    .clk_i(clk), .start_i(start), .memstall_i(ms), .IDEX_MemRead_i(ld),
    .IDEX_RdAddr_i(rd), .IFID_RS1_i(rs1), .IFID_RS2_i(rs2), .Branch_i(br),
    .PCWrite_o(pcw[0]), .IFID_Stall_o(istall[0]), .IFID_Flush_o(iflush[0]),
    .NoOp_o(noop[0]), .Global_stall_o(gstall[0]), .state_o(st0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0), .err_o(err[0])
  );

  hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut1 (
    .clk_i(clk), .start_i(start), .memstall_i(ms), .IDEX_MemRead_i(ld),
    .IDEX_RdAddr_i(rd), .IFID_RS1_i(rs1), .IFID_RS2_i(rs2), .Branch_i(br),
    .PCWrite_o(pcw[1]), .IFID_Stall_o(istall[1]), .IFID_Flush_o(iflush[1]),
    .NoOp_o(noop[1]), .Global_stall_o(gstall[1]), .state_o(st1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {PCWrite, IFID_Stall, IFID_Flush, NoOp, Global_stall}
  function automatic logic [4:0] exp_ctrl(int st);
    bit hz;
    hz = ld && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    if (!start || st == 0) return 5'b00100;
    if (ms)                return 5'b00001;
    if (hz)                return 5'b01010;
    if (br)                return 5'b10100;
    return 5'b10000;
  endfunction

  task automatic model_step();
    logic [4:0] c;
    for (int k = 0; k < 2; k++) begin
      if (!start) begin
        m_st[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_dw[k] = 0; m_err[k] = 1'b0;
      end else begin
        c = exp_ctrl(m_st[k]);
        if (m_st[k] != 0) begin
          if (!c[4] && m_sc[k] < m_cmax[k]) m_sc[k]++;
          if (c[2] && m_fc[k] < m_cmax[k])  m_fc[k]++;
        end
        if (m_dw[k] == m_to[k]) m_err[k] = 1'b1;
        case (m_st[k])
          0: m_st[k] = 1;
          1: if (ms) begin m_st[k] = 2; m_dw[k] = 0; end
          default: begin
            if (ms) begin
              if (m_dw[k] < m_to[k]) m_dw[k]++;
            end else m_st[k] = 1;
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    ms = 1'b0; ld = 1'b0; br = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if ({pcw[0], istall[0], iflush[0], noop[0], gstall[0]} !== 5'b00100 || st0 !== 2'b00 ||
        sc0 !== 16'd0 || fc0 !== 16'd0 || err[0] !== 1'b0)
      $display("FAIL reset_state: ctrl=%b st=%b sc=%0d fc=%0d err=%b, want ctrl=00100 st=00 0 0 0",
               {pcw[0], istall[0], iflush[0], noop[0], gstall[0]}, st0, sc0, fc0, err[0]);
    else n_pass++;
    start = 1'b1;
    #1;
    n_checks++;
    if (st0 !== 2'b00 || iflush[0] !== 1'b1 || pcw[0] !== 1'b0)
      $display("FAIL release_idle: st=%b flush=%b pcw=%b, want 00 1 0", st0, iflush[0], pcw[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (st0 !== 2'b01 || pcw[0] !== 1'b1 || sc0 !== 16'd0 || fc0 !== 16'd0)
      $display("FAIL run_entry: st=%b pcw=%b sc=%0d fc=%0d, want 01 1 0 0", st0, pcw[0], sc0, fc0);
    else n_pass++;
  endtask

  task automatic test_load_use();
    ld = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    n_checks++;
    if ({pcw[0], istall[0], noop[0], iflush[0]} !== 4'b0110)
      $display("FAIL load_use_ctrl: pcw/stall/noop/flush=%b, want 0110",
               {pcw[0], istall[0], noop[0], iflush[0]});
    else n_pass++;
    tick();
    n_checks++;
    if (sc0 !== 16'd1) $display("FAIL load_use_cnt: stall_cnt=%0d, want 1", sc0);
    else n_pass++;
    rd = 5'd0; rs1 = 5'd0;
    #1;
    n_checks++;
    if (pcw[0] !== 1'b1 || istall[0] !== 1'b0 || noop[0] !== 1'b0)
      $display("FAIL rd_zero: pcw=%b stall=%b noop=%b, want 1 0 0", pcw[0], istall[0], noop[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (sc0 !== 16'd1) $display("FAIL rd_zero_cnt: stall_cnt=%0d, want 1", sc0);
    else n_pass++;
  endtask

  task automatic test_branch();
    ld = 1'b1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; br = 1'b1;
    #1;
    n_checks++;
    if ({istall[0], iflush[0], noop[0]} !== 3'b101)
      $display("FAIL branch_hazard: stall/flush/noop=%b, want 101", {istall[0], iflush[0], noop[0]});
    else n_pass++;
    tick();
    n_checks++;
    if (fc0 !== 16'd0 || sc0 !== 16'd2)
      $display("FAIL branch_hazard_cnt: fc=%0d sc=%0d, want 0 2", fc0, sc0);
    else n_pass++;
    ld = 1'b0;
    #1;
    n_checks++;
    if ({pcw[0], istall[0], iflush[0], noop[0]} !== 4'b1010)
      $display("FAIL branch_flush: pcw/stall/flush/noop=%b, want 1010",
               {pcw[0], istall[0], iflush[0], noop[0]});
    else n_pass++;
    tick();
    n_checks++;
    if (fc0 !== 16'd1) $display("FAIL branch_cnt: flush_cnt=%0d, want 1", fc0);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_memstall();
    int gs_cycles = 0;
    ms = 1'b1; ld = 1'b1; rd = 5'd4; rs1 = 5'd4;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (gstall[0] === 1'b1 && pcw[0] === 1'b0 && noop[0] === 1'b0) gs_cycles++;
      tick();
    end
    n_checks++;
    if (gs_cycles != 10) $display("FAIL memstall_gs: freeze cycles=%0d, want 10", gs_cycles);
    else n_pass++;
    n_checks++;
    if (st0 !== 2'b10 || sc0 !== 16'd12 || err[0] !== 1'b0)
      $display("FAIL memstall_state: st=%b sc=%0d err=%b, want 10 12 0", st0, sc0, err[0]);
    else n_pass++;
    clear_inputs();
    #1;
    n_checks++;
    if (pcw[0] !== 1'b1 || gstall[0] !== 1'b0)
      $display("FAIL memstall_release: pcw=%b gs=%b, want 1 0", pcw[0], gstall[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (st0 !== 2'b01) $display("FAIL memstall_run: st=%b, want 01", st0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    start = 1'b0; tick();
    start = 1'b1; tick();
    ms = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (err[1] !== (k >= 6) || err[0] !== 1'b0)
        $display("FAIL timeout_err_%0d: err_small=%b err_def=%b, want %b 0", k, err[1], err[0], (k >= 6));
      else n_pass++;
    end
    ms = 1'b0; tick();
    n_checks++;
    if (err[1] !== 1'b1) $display("FAIL timeout_sticky: err=%b, want 1", err[1]);
    else n_pass++;
    start = 1'b0; tick();
    n_checks++;
    if (err[1] !== 1'b0) $display("FAIL timeout_clear: err=%b, want 0", err[1]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    start = 1'b1; tick();
    ld = 1'b1; rd = 5'd9; rs1 = 5'd9;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (sc1 !== 4'((k > 15) ? 15 : k) || sc0 !== 16'(k))
        $display("FAIL sat_%0d: small=%0d def=%0d, want %0d %0d", k, sc1, sc0, (k > 15) ? 15 : k, k);
      else n_pass++;
    end
    ld = 1'b0; ms = 1'b1;
    tick(); tick();
    start = 1'b0;
    #1;
    n_checks++;
    if ({pcw[1], iflush[1], gstall[1]} !== 3'b010 || st1 !== 2'b10)
      $display("FAIL reset_in_memwait_ctrl: pcw/flush/gs=%b st=%b, want 010 10",
               {pcw[1], iflush[1], gstall[1]}, st1);
    else n_pass++;
    tick();
    n_checks++;
    if (st1 !== 2'b00 || sc1 !== 4'd0 || fc1 !== 4'd0 || st0 !== 2'b00 || sc0 !== 16'd0)
      $display("FAIL reset_in_memwait: st=%b sc=%0d fc=%0d, want 00 0 0", st1, sc1, fc1);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    int ms_hold = 0;
    logic [1:0] stv;
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 39) != 0);
      if (ms_hold == 0 && $urandom_range(0, 7) == 0) ms_hold = $urandom_range(1, 9);
      ms = (ms_hold > 0);
      if (ms_hold > 0) ms_hold--;
      ld  = 1'($urandom_range(0, 1));
      br  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      #1;
      for (int k = 0; k < 2; k++) begin
        stv = (k == 0) ? st0 : st1;
        n_checks++;
        if ({pcw[k], istall[k], iflush[k], noop[k], gstall[k], stv, err[k]} !==
            {exp_ctrl(m_st[k]), 2'(m_st[k]), m_err[k]})
          $display("FAIL rand_%0d_inst%0d: ctrl/st/err=%b, want %b", i, k,
                   {pcw[k], istall[k], iflush[k], noop[k], gstall[k], stv, err[k]},
                   {exp_ctrl(m_st[k]), 2'(m_st[k]), m_err[k]});
        else n_pass++;
      end
      n_checks++;
      if (sc0 !== 16'(m_sc[0]) || fc0 !== 16'(m_fc[0]) || sc1 !== 4'(m_sc[1]) || fc1 !== 4'(m_fc[1]))
        $display("FAIL rand_cnt_%0d: %0d %0d %0d %0d, want %0d %0d %0d %0d", i,
                 sc0, fc0, sc1, fc1, m_sc[0], m_fc[0], m_sc[1], m_fc[1]);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_dw[k] = 0; m_err[k] = 1'b0;
    end
    test_reset();
    test_load_use();
    test_branch();
    test_memstall();
    test_timeout();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
